// File: rtl/mcc_pkg.sv
// Shared encodings for the multicycle controller: opcodes, ALU/mux codes, states, control bundle.
// No logic; latency n/a; no backpressure.
// Imported by mcc_outdec and multicycle_ctrl.
package mcc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [2:0] ALU_SUB   = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SLT   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: is_legal_op = 1'b1;
            default:                            is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mcc_outdec.sv
// Control decode: state (+opcode in DECODE/IMMEX, +mem_ready in FETCH) -> datapath controls.
// Latency: combinational; backpressure: mem_ready=0 suppresses pc_write/ir_write in FETCH.
// reset forces every strobe and illegal_op low.
module mcc_outdec
    import mcc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       reset,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMMSH2;
                ctrl.illegal_op = !is_legal_op(opcode);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_REXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_RTYPE;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_IMMEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_SLTI: ctrl.alu_op = ALU_SLT;
                    OP_ANDI: ctrl.alu_op = ALU_AND;
                    OP_ORI:  ctrl.alu_op = ALU_OR;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            S_IMMWB: ctrl.reg_write = 1'b1;
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase

        // Reset lands on FETCH, whose strobes must not fire until reset drops.
        if (reset) begin
            ctrl.pc_write      = 1'b0;
            ctrl.pc_write_cond = 1'b0;
            ctrl.mem_read      = 1'b0;
            ctrl.mem_write     = 1'b0;
            ctrl.ir_write      = 1'b0;
            ctrl.reg_write     = 1'b0;
            ctrl.illegal_op    = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main controller: state register + next-state; decode lives in mcc_outdec.
// Latency: lw 5, sw/R/imm 4, beq/j 3, illegal 2 cycles; MCC_MEM_WAIT_EN makes FETCH/MEMRD/MEMWR hold on mem_ready=0.
// Without MCC_MEM_WAIT_EN mem_ready is ignored.
module multicycle_ctrl
    import mcc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t r_state;
    state_t w_next;
    logic   w_mem_ok;
    ctrl_t  w_ctrl;

`ifdef MCC_MEM_WAIT_EN
    assign w_mem_ok = mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = mem_ready;
    assign w_mem_ok           = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = w_mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                         w_next = S_REXEC;
                    OP_LW, OP_SW:                     w_next = S_MEMADR;
                    OP_BEQ:                           w_next = S_BEQ;
                    OP_J:                             w_next = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_next = S_IMMEX;
                    default:                          w_next = S_FETCH;
                endcase
            end
            // An opcode that is neither lw nor sw here is abandoned back to FETCH.
            S_MEMADR: begin
                if (opcode == OP_LW)      w_next = S_MEMRD;
                else if (opcode == OP_SW) w_next = S_MEMWR;
                else                      w_next = S_FETCH;
            end
            S_MEMRD:  w_next = w_mem_ok ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = w_mem_ok ? S_FETCH : S_MEMWR;
            S_REXEC:  w_next = S_RWB;
            S_RWB:    w_next = S_FETCH;
            S_BEQ:    w_next = S_FETCH;
            S_IMMEX:  w_next = S_IMMWB;
            S_IMMWB:  w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    mcc_outdec u_outdec (
        .state     (r_state),
        .opcode    (opcode),
        .mem_ready (w_mem_ok),
        .reset     (reset),
        .ctrl      (w_ctrl)
    );

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign iord          = w_ctrl.iord;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign reg_dst       = w_ctrl.reg_dst;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign reg_write     = w_ctrl.reg_write;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign pc_source     = w_ctrl.pc_source;
    assign illegal_op    = w_ctrl.illegal_op;
    assign state         = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through the FSM, checks
// states and controls against hand-derived values; covers reset, illegal ops and mem_ready.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;

    int n_vec = 0;
    int n_err = 0;

    multicycle_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run a full immediate instruction from FETCH and check its ALU op in IMMEX.
    task automatic run_imm(input logic [5:0] op, input logic [2:0] exp_alu);
        opcode = op;
        tick();
        chk("imm_decode_state", 8'(state), 8'd1);
        tick();
        chk("imm_immex_state", 8'(state), 8'd9);
        chk("imm_alu_op", 8'(alu_op), 8'(exp_alu));
        chk("imm_alu_src_b", 8'(alu_src_b), 8'd2);
        chk("imm_alu_src_a", 8'(alu_src_a), 8'd1);
        tick();
        chk("imm_immwb_state", 8'(state), 8'd10);
        chk("imm_reg_write", 8'(reg_write), 8'd1);
        chk("imm_reg_dst", 8'(reg_dst), 8'd0);
        tick();
        chk("imm_back_fetch", 8'(state), 8'd0);
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'b100011;
        mem_ready = 1'b1;

        // Two reset cycles: state FETCH, strobes held low.
        tick();
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_pc_write", 8'(pc_write), 8'd0);
        chk("rst_mem_read", 8'(mem_read), 8'd0);
        chk("rst_ir_write", 8'(ir_write), 8'd0);
        chk("rst_illegal", 8'(illegal_op), 8'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("fetch_mem_read", 8'(mem_read), 8'd1);
        chk("fetch_ir_write", 8'(ir_write), 8'd1);
        chk("fetch_pc_write", 8'(pc_write), 8'd1);
        chk("fetch_alu_src_b", 8'(alu_src_b), 8'd1);
        chk("fetch_alu_op", 8'(alu_op), 8'd1);
        chk("fetch_pc_source", 8'(pc_source), 8'd0);

        // lw: 0,1,2,3,4,0
        tick();
        chk("lw_s1", 8'(state), 8'd1);
        chk("lw_dec_src_b", 8'(alu_src_b), 8'd3);
        chk("lw_dec_illegal", 8'(illegal_op), 8'd0);
        tick();
        chk("lw_s2", 8'(state), 8'd2);
        chk("lw_memadr_src_a", 8'(alu_src_a), 8'd1);
        chk("lw_memadr_src_b", 8'(alu_src_b), 8'd2);
        tick();
        chk("lw_s3", 8'(state), 8'd3);
        chk("lw_memrd_rd", 8'(mem_read), 8'd1);
        chk("lw_memrd_iord", 8'(iord), 8'd1);
        chk("lw_memrd_regwr", 8'(reg_write), 8'd0);
        tick();
        chk("lw_s4", 8'(state), 8'd4);
        chk("lw_memwb_regwr", 8'(reg_write), 8'd1);
        chk("lw_memwb_m2r", 8'(mem_to_reg), 8'd1);
        chk("lw_memwb_regdst", 8'(reg_dst), 8'd0);
        tick();
        chk("lw_s0", 8'(state), 8'd0);
        chk("lw_fetch_regwr", 8'(reg_write), 8'd0);
        chk("lw_fetch_m2r", 8'(mem_to_reg), 8'd0);

        // R-type; opcode change during REXEC must not matter.
        opcode = 6'b000000;
        tick();
        chk("r_s1", 8'(state), 8'd1);
        tick();
        chk("r_s6", 8'(state), 8'd6);
        chk("r_alu_op", 8'(alu_op), 8'd7);
        chk("r_src_b", 8'(alu_src_b), 8'd0);
        opcode = 6'b100011;
        tick();
        chk("r_s7", 8'(state), 8'd7);
        chk("r_regwr", 8'(reg_write), 8'd1);
        chk("r_regdst", 8'(reg_dst), 8'd1);
        tick();
        chk("r_s0", 8'(state), 8'd0);

        run_imm(6'b001010, 3'b010);
        run_imm(6'b001000, 3'b001);
        run_imm(6'b001100, 3'b011);
        run_imm(6'b001101, 3'b100);

        // beq: 3-cycle loop
        opcode = 6'b000100;
        tick();
        chk("beq_s1", 8'(state), 8'd1);
        tick();
        chk("beq_s8", 8'(state), 8'd8);
        chk("beq_alu_op", 8'(alu_op), 8'd0);
        chk("beq_pwc", 8'(pc_write_cond), 8'd1);
        chk("beq_pc_src", 8'(pc_source), 8'd1);
        chk("beq_pc_write", 8'(pc_write), 8'd0);
        tick();
        chk("beq_s0", 8'(state), 8'd0);

        // jump
        opcode = 6'b000010;
        tick();
        tick();
        chk("j_s11", 8'(state), 8'd11);
        chk("j_pc_write", 8'(pc_write), 8'd1);
        chk("j_pc_src", 8'(pc_source), 8'd2);
        tick();
        chk("j_s0", 8'(state), 8'd0);

        // illegal opcode: one-cycle pulse in DECODE
        opcode = 6'b111111;
        chk("ill_fetch_pulse", 8'(illegal_op), 8'd0);
        tick();
        chk("ill_s1", 8'(state), 8'd1);
        chk("ill_pulse", 8'(illegal_op), 8'd1);
        tick();
        chk("ill_s0", 8'(state), 8'd0);
        chk("ill_pulse_gone", 8'(illegal_op), 8'd0);

        // sw interrupted by reset in MEMWR
        opcode = 6'b101011;
        tick();
        tick();
        tick();
        chk("sw_s5", 8'(state), 8'd5);
        chk("sw_mem_write", 8'(mem_write), 8'd1);
        chk("sw_iord", 8'(iord), 8'd1);
        reset = 1'b1;
        #1;
        chk("sw_rst_mem_write", 8'(mem_write), 8'd0);
        tick();
        chk("sw_rst_s0", 8'(state), 8'd0);
        chk("sw_rst_mem_read", 8'(mem_read), 8'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ir_write", 8'(ir_write), 8'd1);

        // mem_ready handling in FETCH
        mem_ready = 1'b0;
        #1;
`ifdef MCC_MEM_WAIT_EN
        for (int i = 0; i < 3; i++) begin
            chk("wait_ir_write", 8'(ir_write), 8'd0);
            chk("wait_pc_write", 8'(pc_write), 8'd0);
            chk("wait_mem_read", 8'(mem_read), 8'd1);
            tick();
            chk("wait_state", 8'(state), 8'd0);
        end
        mem_ready = 1'b1;
        #1;
        chk("ready_ir_write", 8'(ir_write), 8'd1);
        chk("ready_pc_write", 8'(pc_write), 8'd1);
        tick();
        chk("ready_s1", 8'(state), 8'd1);
`else
        chk("nowait_ir_write", 8'(ir_write), 8'd1);
        chk("nowait_pc_write", 8'(pc_write), 8'd1);
        tick();
        chk("nowait_s1", 8'(state), 8'd1);
        mem_ready = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
